// File: rtl/mdu_unit_pkg.sv
// Shared multiply/divide operation codes for the E-stage decoder and mdu_unit.
package mdu_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MADD  = 3'd7
  } mdop_e;

endpackage

// File: rtl/mdu_unit_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
interface mdu_unit_if;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdop, a, b, flush, input busy, hi, lo);
  modport slave  (input start, mdop, a, b, flush, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; fixed latency per op class.
// Define MDU_MADD_EN to enable mdop=7 (madd: {hi,lo} += signed a*b).
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt;
  logic [XLEN-1:0]    hi_q;
  logic [XLEN-1:0]    lo_q;
  logic [2*XLEN-1:0]  pend;
  logic               pend_skip;

  mdop_e              op;
  logic [2*XLEN-1:0]  calc;
  logic               calc_long;
  logic               calc_skip;
  logic [CNT_W-1:0]   calc_cnt;
  logic signed [2*XLEN-1:0] sprod;
  logic signed [XLEN-1:0]   sa;
  logic signed [XLEN-1:0]   sb;
  logic                     div_ovf;

`ifdef MDU_MADD_EN
  logic calc_acc;
  logic pend_acc;
`endif

  assign op      = mdop_e'(bus.mdop);
  assign sa      = $signed(bus.a);
  assign sb      = $signed(bus.b);
  assign sprod   = $signed({{XLEN{bus.a[XLEN-1]}}, bus.a}) * $signed({{XLEN{bus.b[XLEN-1]}}, bus.b});
  // The one signed-quotient case that does not fit in 32 bits is pinned explicitly.
  assign div_ovf = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);

  always_comb begin
    calc      = '0;
    calc_long = 1'b0;
    calc_skip = 1'b0;
    calc_cnt  = CNT_W'(MULT_CYCLES - 1);
`ifdef MDU_MADD_EN
    calc_acc  = 1'b0;
`endif
    case (op)
      MD_MULT: begin
        calc      = sprod;
        calc_long = 1'b1;
      end
      MD_MULTU: begin
        calc      = {32'h0, bus.a} * {32'h0, bus.b};
        calc_long = 1'b1;
      end
      MD_DIV: begin
        calc_long = 1'b1;
        calc_cnt  = CNT_W'(DIV_CYCLES - 1);
        if (bus.b == '0)  calc_skip = 1'b1;
        else if (div_ovf) calc      = {32'h0, 32'h8000_0000};
        else              calc      = {sa % sb, sa / sb};
      end
      MD_DIVU: begin
        calc_long = 1'b1;
        calc_cnt  = CNT_W'(DIV_CYCLES - 1);
        if (bus.b == '0) calc_skip = 1'b1;
        else             calc      = {bus.a % bus.b, bus.a / bus.b};
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        calc      = sprod;
        calc_long = 1'b1;
        calc_acc  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy_q    <= 1'b0;
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend      <= '0;
      pend_skip <= 1'b0;
`ifdef MDU_MADD_EN
      pend_acc  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            if (op == MD_MTHI) begin
              hi_q <= bus.a;
            end else if (op == MD_MTLO) begin
              lo_q <= bus.a;
            end else if (calc_long) begin
              state     <= S_RUN;
              busy_q    <= 1'b1;
              cnt       <= calc_cnt;
              pend      <= calc;
              pend_skip <= calc_skip;
`ifdef MDU_MADD_EN
              pend_acc  <= calc_acc;
`endif
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (cnt == '0) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            if (!pend_skip) begin
`ifdef MDU_MADD_EN
              {hi_q, lo_q} <= pend_acc ? ({hi_q, lo_q} + pend) : pend;
`else
              {hi_q, lo_q} <= pend;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: random and directed ops vs. an arithmetic reference model.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mdu_unit_if bus();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  int          bcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural meaning of each op.
  function automatic void model(input int op, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] h, input logic [31:0] l,
                                output logic [31:0] nh, output logic [31:0] nl, output int lat);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    longint      qv;
    longint      rv;
    logic [63:0] p;
    nh = h; nl = l; lat = 0;
    case (op)
      1: begin p = sx * sy; {nh, nl} = p; lat = MC; end
      2: begin p = {32'h0, x} * {32'h0, y}; {nh, nl} = p; lat = MC; end
      3: begin
        lat = DC;
        if (y != 0) begin qv = sx / sy; rv = sx % sy; nl = qv[31:0]; nh = rv[31:0]; end
      end
      4: begin
        lat = DC;
        if (y != 0) begin nl = x / y; nh = x % y; end
      end
      5: nh = x;
      6: nl = x;
`ifdef MDU_MADD_EN
      7: begin p = {h, l} + 64'(sx * sy); {nh, nl} = p; lat = MC; end
`endif
      default: ;
    endcase
  endfunction

  // Monitor: every busy->idle transition is an output event checked against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy === 1'b1) begin
      bcnt++;
    end else if (bcnt > 0) begin
      if (q.size() == 0) begin
        chk("unexpected_commit", 64'(bcnt), 64'd0);
      end else begin
        e = q.pop_front();
        chk("busy_cycles", 64'(bcnt), 64'(e.lat));
        chk("hi_commit", 64'(bus.hi), 64'(e.hi));
        chk("lo_commit", 64'(bus.lo), 64'(e.lo));
      end
      bcnt = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy !== 1'b0) chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  // Called at #1 after a rising edge; returns in the first cycle busy reads 0.
  task automatic run_op(input int op, input logic [31:0] x, input logic [31:0] y, input bit probe);
    logic [31:0] nh, nl;
    int lat;
    model(op, x, y, mhi, mlo, nh, nl, lat);
    if (lat > 0) q.push_back('{nh, nl, lat});
    bus.start = 1'b1; bus.mdop = op[2:0]; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.mdop = 3'($urandom);
    mhi = nh; mlo = nl;
    if (lat == 0) begin
      chk("busy_short_op", 64'(bus.busy), 64'd0);
      chk("hi_short_op", 64'(bus.hi), 64'(mhi));
      chk("lo_short_op", 64'(bus.lo), 64'(mlo));
    end else begin
      if (probe) begin
        bus.start = 1'b1; bus.mdop = 3'd5; bus.a = $urandom;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      wait_idle();
    end
  endtask

  task automatic abort_run(input bit use_reset);
    q.push_back('{use_reset ? 32'h0 : mhi, use_reset ? 32'h0 : mlo, 4});
    bus.start = 1'b1; bus.mdop = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    if (use_reset) reset = 1'b1; else bus.flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.flush = 1'b0;
    if (use_reset) begin mhi = '0; mlo = '0; end
    chk(use_reset ? "busy_after_reset" : "busy_after_flush", 64'(bus.busy), 64'd0);
    chk("hi_after_abort", 64'(bus.hi), 64'(mhi));
    chk("lo_after_abort", 64'(bus.lo), 64'(mlo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.mdop = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);

    run_op(1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    run_op(2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(4, 32'd7, 32'd0, 1'b0);
    run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(5, 32'h1234_5678, 32'd0, 1'b0);
    run_op(6, 32'h9ABC_DEF0, 32'd0, 1'b0);

    // start together with flush in idle must be dropped, mthi included
    bus.flush = 1'b1; bus.start = 1'b1; bus.mdop = 3'd5; bus.a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    chk("hi_flushed_mthi", 64'(bus.hi), 64'(mhi));
    chk("busy_flushed_start", 64'(bus.busy), 64'd0);

    abort_run(1'b0);
    abort_run(1'b1);

    run_op(6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(5, 32'h0, 32'd0, 1'b0);
    run_op(7, 32'd1, 32'd1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage. It executes the HI/LO-class operations that the E-stage decoder steers away from the single-cycle ALU.
- It accepts an operation code plus two 32-bit operands on a one-cycle start pulse, holds busy for a fixed latency, then commits the result to the HI/LO registers.
- HI and LO are exposed continuously so mfhi/mflo can read them.
- The hazard unit stalls D on (start || busy) when a HI/LO instruction is decoded.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (and madd when enabled); must be >= 1.
- DIV_CYCLES, 10, number of busy cycles for div/divu; must be >= 1.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request pulse; qualifies mdop, a, b.
- mdop  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd (optional).
- a  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- b  input  32  rt operand (divisor / multiplier).
- flush  input  1  abort request from exception/interrupt logic.
- busy  output  1  registered; high while a mult/div is in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, state=IDLE, counter=0, pending result cleared. Reset overrides start and flush in the same cycle. Reset mid-operation aborts the operation with no commit.
- States:
  - IDLE: busy=0.
  - RUN: busy=1. Counter loads N-1 on entry and decrements each cycle. When counter==0 and flush=0, the next edge commits the pending {hi,lo} and returns to IDLE.
- Acceptance:
  - start is honoured only in IDLE. start while busy=1 is ignored; upstream stall makes this illegal, but RTL must tolerate it.
  - start with mdop=0 is a no-op.
- Operand capture: a, b and mdop are sampled at the start edge. The result is computed from the captured values into a pending register. Input changes during RUN have no effect.
- Latency:
  - mult/multu: busy high exactly MULT_CYCLES cycles, starting the cycle after start. hi/lo show the new value in the cycle busy first reads 0.
  - div/divu: same rule with DIV_CYCLES.
- mthi/mtlo: written at the start edge with no busy cycle; the new value is visible the next cycle. The other register is unchanged.
- Arithmetic:
  - mult: {hi,lo} = signed 64-bit a*b.
  - multu: unsigned 64-bit a*b.
  - div: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (div or divu): runs the full DIV_CYCLES, hi/lo unchanged at commit.
- Flush:
  - flush=1 in RUN: return to IDLE next edge, busy=0, no commit, hi/lo unchanged.
  - flush=1 with start in IDLE: start is dropped, including mthi/mtlo.
  - flush in IDLE without start: no effect.
- Back-to-back: a new start is accepted in the first cycle with busy=0. There is no dead cycle after commit.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: mdop=7 is madd, {hi,lo} = {hi,lo} + signed a*b (64-bit wrap). The accumulate uses hi/lo as they stand at commit time, with MULT_CYCLES latency.
- Not defined: mdop=7 is treated as mdop=0 (no-op, no busy), and the accumulate datapath is absent.

Decomposition:
- The mdop encodings (md_none, md_mult, md_multu, md_div, md_divu, md_mthi, md_mtlo, md_madd) go in the shared head.v include, alongside the existing alu_* codes. The E-stage decoder and this unit use the same constants.
- State encodings stay local to mdu_unit.
- No sub-module is needed. The product/quotient path is a single combinational block inside mdu_unit feeding the pending register.

Test Plan:
- Reset then idle: hi=lo=0, busy=0. start with mdop=1, a=0xFFFFFFFF, b=2 → busy high 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE. Change a/b during busy → result unchanged.
- div a=-7 (0xFFFFFFF9), b=2 → busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu a=7, b=0 → hi/lo keep previous values after 10 busy cycles.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles → no busy; hi=0x12345678, lo=0x9ABCDEF0 one cycle after each.
- Start div, assert flush on busy cycle 4 → busy drops next cycle, hi/lo unchanged. Repeat with reset instead of flush → hi=lo=0, busy=0.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, madd a=1, b=1 → hi=1, lo=0 after 5 cycles. Without the macro → no busy, hi/lo unchanged.
